// File: rtl/my_test_ahb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// my_test_ahb_reg_arbiter
//
// Purpose:
//   Shares one AHB-lite register-block slave port between two requesters.
//   Arbitration is round-robin. Only one non-pipelined single transfer is in
//   flight at a time, and the response goes back to the requester that won.
//
// Handshake:
//   req[i] is a level. Once raised it stays high until req_ack[i] pulses. The
//   pulse is combinational, in the cycle where the request is consumed.
//   Requests are sampled only in IDLE. A request dropped before its ack is
//   ignored. A request still held after its ack starts a new transfer at the
//   next IDLE. rsp_valid[i] is a single-cycle pulse, and rsp_rdata/rsp_err
//   are meaningful during that pulse. There is no back-pressure on the
//   response.
//
// Ports:
//   RegClk, RegResetN      clock and asynchronous active-low reset
//   req/req_write          per-requester request level and direction (1=write)
//   req_addr/req_wdata     packed per-requester address and write data
//   req_ack                one-hot pulse: request consumed this cycle
//   rsp_valid              one-hot pulse: response for that requester
//   rsp_rdata/rsp_err      read data (0 for writes) and error flag
//   hsel..hwdata           AHB-lite master outputs (all registered)
//   hrdata/hresp/hready    AHB-lite slave response
//   dbg_state              current FSM state (IDLE=0, ADDR=1, DATA=2, RESP=3)
// -----------------------------------------------------------------------------
module my_test_ahb_reg_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    RegClk,
  input  logic                    RegResetN,
  input  logic [1:0]              req,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]             req_wdata,
  output logic [1:0]              req_ack,
  output logic [1:0]              rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    hsel,
  output logic                    hwrite,
  output logic [1:0]              htrans,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [31:0]             hwdata,
  input  logic [31:0]             hrdata,
  input  logic [1:0]              hresp,
  input  logic                    hready,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_last_gnt;
  logic                  r_gnt;
  logic                  r_write;
  logic [31:0]           r_wdata;

  logic                  w_winner;
  logic [1:0]            w_ack;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;

  // State register
  always_ff @(posedge RegClk or negedge RegResetN) begin
    if (!RegResetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and arbitration. On a tie the grant goes to the requester
  // that did not win last time. A sole requester wins regardless of history.
  always_comb begin
    w_next   = r_state;
    w_winner = 1'b0;
    w_ack    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_winner = (req == 2'b11) ? ~r_last_gnt : req[1];
          w_ack    = w_winner ? 2'b10 : 2'b01;
          w_next   = S_ADDR;
        end
      end
      S_ADDR:  w_next = S_DATA;
      S_DATA:  if (hready) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sel_addr  = w_winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : req_addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata = w_winner ? req_wdata[63:32] : req_wdata[31:0];

  // Registered datapath. Every AHB and response output is updated on the
  // transition into the state where it must be visible, so it comes
  // straight from a flop.
  always_ff @(posedge RegClk or negedge RegResetN) begin
    if (!RegResetN) begin
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'h0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      hsel       <= 1'b0;
      hwrite     <= 1'b0;
      htrans     <= 2'b00;
      haddr      <= '0;
      hwdata     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ack != 2'b00) begin
            r_gnt      <= w_winner;
            r_last_gnt <= w_winner;
            r_write    <= req_write[w_winner];
            r_wdata    <= w_sel_wdata;
            hsel       <= 1'b1;
            htrans     <= 2'b10;
            hwrite     <= req_write[w_winner];
            haddr      <= w_sel_addr;
          end
        end
        S_ADDR: begin
          hsel   <= 1'b0;
          htrans <= 2'b00;
          hwdata <= r_write ? r_wdata : 32'h0;
        end
        S_DATA: begin
          // hwdata and haddr stay put while the slave stalls.
          if (hready) begin
            rsp_rdata <= r_write ? 32'h0 : hrdata;
            rsp_err   <= (hresp == 2'b01);
            rsp_valid <= r_gnt ? 2'b10 : 2'b01;
            hwdata    <= 32'h0;
          end
        end
        S_RESP: begin
          rsp_valid <= 2'b00;
        end
        default: begin
          rsp_valid <= 2'b00;
        end
      endcase
    end
  end

  assign req_ack   = w_ack;
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_my_test_ahb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_my_test_ahb_reg_arbiter
//
// Directed bench for the two-requester AHB register arbiter. A small
// behavioural register-block slave answers the arbiter:
//   0x00 RO 0x0000_0804, 0x04 RO 0x0700_04D2, 0x08 RO 0x0000_0005,
//   0x0C RW swi_blabla, anything else returns an error response.
// Inputs are driven on the falling clock edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_my_test_ahb_reg_arbiter;

  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic          RegClk = 1'b0;
  logic          RegResetN = 1'b0;
  always #5 RegClk = ~RegClk;

  logic [1:0]    req = 2'b00;
  logic [1:0]    req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = 64'h0;
  logic [1:0]    req_ack;
  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          hsel;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [AW-1:0] haddr;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic [1:0]    hresp;
  logic          hready = 1'b1;
  logic [1:0]    dbg_state;

  my_test_ahb_reg_arbiter #(.ADDR_WIDTH(AW)) dut (
    .RegClk    (RegClk),
    .RegResetN (RegResetN),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .hsel      (hsel),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hsize     (hsize),
    .hburst    (hburst),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hresp     (hresp),
    .hready    (hready),
    .dbg_state (dbg_state)
  );

  // ---------------- slave model ----------------
  logic          s_dphase;
  logic          s_write;
  logic [AW-1:0] s_addr;
  logic [31:0]   swi_blabla = 32'h0;
  logic [31:0]   m_rdata;
  logic          m_err;

  always @(posedge RegClk or negedge RegResetN) begin
    if (!RegResetN) begin
      s_dphase <= 1'b0;
      s_write  <= 1'b0;
      s_addr   <= '0;
    end else begin
      if (s_dphase && hready) s_dphase <= 1'b0;
      if (hsel && htrans == 2'b10 && hready) begin
        s_dphase <= 1'b1;
        s_addr   <= haddr;
        s_write  <= hwrite;
      end
    end
  end

  always @(posedge RegClk) begin
    if (RegResetN && s_dphase && hready && s_write && s_addr == 8'h0C)
      swi_blabla <= hwdata;
  end

  always_comb begin
    m_rdata = 32'h0;
    m_err   = 1'b0;
    case (s_addr)
      8'h00:   m_rdata = 32'h0000_0804;
      8'h04:   m_rdata = 32'h0700_04D2;
      8'h08:   m_rdata = 32'h0000_0005;
      8'h0C:   m_rdata = swi_blabla;
      default: m_err   = 1'b1;
    endcase
  end

  assign hrdata = (s_dphase && !s_write && !m_err) ? m_rdata : 32'h0;
  assign hresp  = (s_dphase && m_err) ? 2'b01 : 2'b00;

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input logic wr, input logic [AW-1:0] a,
                           input logic [31:0] d);
    req[id]       = 1'b1;
    req_write[id] = wr;
    if (id == 1) begin
      req_addr[2*AW-1:AW] = a;
      req_wdata[63:32]    = d;
    end else begin
      req_addr[AW-1:0]    = a;
      req_wdata[31:0]     = d;
    end
  endtask

  // One complete transfer with hready high: ack at T, address phase T+1,
  // response at T+3.
  task automatic xfer(input string tag, input int id, input logic wr,
                      input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    @(negedge RegClk);
    drive_req(id, wr, a, d);
    #1 check({tag, "_ack"}, req_ack, oh);
    @(negedge RegClk);
    req = 2'b00;
    #1;
    check({tag, "_htrans"}, htrans, 2'b10);
    check({tag, "_haddr"}, haddr, a);
    check({tag, "_hwrite"}, hwrite, wr);
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 20) begin
      @(negedge RegClk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_rsp_valid"}, rsp_valid, oh);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, rsp_err, exp_err);
    @(negedge RegClk);
    #1 check({tag, "_rsp_clr"}, rsp_valid, 2'b00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]  exp_ack;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_rd;

    // Reset state
    repeat (2) @(negedge RegClk);
    #1;
    check("rst_req_ack", req_ack, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_hsel", hsel, 1'b0);
    check("rst_htrans", htrans, 2'b00);
    check("rst_hsize", hsize, 3'b010);
    check("rst_hburst", hburst, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    @(negedge RegClk);
    RegResetN = 1'b1;

    // 1: req0 reads 0x0
    xfer("t1", 0, 1'b0, 8'h00, 32'h0, 32'h0000_0804, 1'b0);

    // 3: unmapped read errors, then a normal read
    xfer("t3_err", 0, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1);
    xfer("t3_ok", 0, 1'b0, 8'h04, 32'h0, 32'h0700_04D2, 1'b0);

    // 2: req1 write then read back
    xfer("t2_wr", 1, 1'b1, 8'h0C, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("t2_swi", swi_blabla, 32'hDEAD_BEEF);
    xfer("t2_rd", 1, 1'b0, 8'h0C, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // 5: write with hready held low for three data-phase cycles
    @(negedge RegClk);
    drive_req(1, 1'b1, 8'h0C, 32'h1234_5678);
    #1 check("t5_ack", req_ack, 2'b10);
    @(negedge RegClk);
    req = 2'b00;
    #1 check("t5_htrans", htrans, 2'b10);
    for (int s = 0; s < 3; s++) begin
      @(negedge RegClk);
      hready = 1'b0;
      #1;
      check($sformatf("t5_stall%0d_hsel", s), hsel, 1'b0);
      check($sformatf("t5_stall%0d_htrans", s), htrans, 2'b00);
      check($sformatf("t5_stall%0d_haddr", s), haddr, 8'h0C);
      check($sformatf("t5_stall%0d_hwdata", s), hwdata, 32'h1234_5678);
      check($sformatf("t5_stall%0d_rsp", s), rsp_valid, 2'b00);
    end
    @(negedge RegClk);
    hready = 1'b1;
    #1;
    check("t5_release_hwdata", hwdata, 32'h1234_5678);
    check("t5_release_rsp", rsp_valid, 2'b00);
    @(negedge RegClk);
    #1;
    check("t5_rsp_valid", rsp_valid, 2'b10);
    check("t5_rdata", rsp_rdata, 32'h0);
    check("t5_err", rsp_err, 1'b0);
    check("t5_hwdata_clr", hwdata, 32'h0);
    check("t5_swi", swi_blabla, 32'h1234_5678);

    // 4: both requesters held high; last grant was requester 1
    @(negedge RegClk);
    req_addr  = {8'h04, 8'h00};
    req_write = 2'b00;
    req       = 2'b11;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge RegClk);
      if (c == 15) req = 2'b00;
      #1;
      exp_ack = (c % 4 == 0) ? (((c / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_rsp = (c % 4 == 3) ? (((c / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_rd  = ((c / 4) % 2 == 1) ? 32'h0700_04D2 : 32'h0000_0804;
      check($sformatf("t4_ack_c%0d", c), req_ack, exp_ack);
      check($sformatf("t4_rsp_c%0d", c), rsp_valid, exp_rsp);
      if (c % 4 == 3) check($sformatf("t4_rdata_c%0d", c), rsp_rdata, exp_rd);
    end
    @(negedge RegClk);
    #1 check("t4_idle_ack", req_ack, 2'b00);

    // 6: reset asserted during the data phase
    @(negedge RegClk);
    drive_req(0, 1'b0, 8'h08, 32'h0);
    #1 check("t6_ack", req_ack, 2'b01);
    @(negedge RegClk);
    req = 2'b00;
    @(negedge RegClk);
    #1 check("t6_in_data", dbg_state, 2'd2);
    RegResetN = 1'b0;
    #1;
    check("t6_rst_state", dbg_state, 2'd0);
    check("t6_rst_hsel", hsel, 1'b0);
    check("t6_rst_htrans", htrans, 2'b00);
    check("t6_rst_haddr", haddr, 8'h00);
    check("t6_rst_hwrite", hwrite, 1'b0);
    check("t6_rst_hwdata", hwdata, 32'h0);
    check("t6_rst_rsp_valid", rsp_valid, 2'b00);
    check("t6_rst_rdata", rsp_rdata, 32'h0);
    check("t6_rst_err", rsp_err, 1'b0);
    @(negedge RegClk);
    RegResetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge RegClk);
      #1 check($sformatf("t6_no_rsp%0d", k), rsp_valid, 2'b00);
    end
    xfer("t6_rd", 0, 1'b0, 8'h08, 32'h0, 32'h0000_0005, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
